// File: rtl/axi_cmd_arbiter_if.sv
// Signal bundle between the two command requesters, axi_cmd_arbiter and the
// axi_lite_master command port. The arbiter uses the master modport. The
// requesters and the master-side logic use the slave modport.
interface axi_cmd_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  r0_cmd_valid;
    logic                  r0_cmd_we;
    logic [ADDR_WIDTH-1:0] r0_cmd_addr;
    logic [DATA_WIDTH-1:0] r0_cmd_wdata;
    logic                  r0_cmd_ready;
    logic                  r0_rsp_valid;
    logic [DATA_WIDTH-1:0] r0_rsp_rdata;
    logic                  r0_rsp_err;
    logic                  r0_rsp_ready;

    logic                  r1_cmd_valid;
    logic                  r1_cmd_we;
    logic [ADDR_WIDTH-1:0] r1_cmd_addr;
    logic [DATA_WIDTH-1:0] r1_cmd_wdata;
    logic                  r1_cmd_ready;
    logic                  r1_rsp_valid;
    logic [DATA_WIDTH-1:0] r1_rsp_rdata;
    logic                  r1_rsp_err;
    logic                  r1_rsp_ready;

    logic                  mwr_valid;
    logic [DATA_WIDTH-1:0] mwr_data;
    logic [ADDR_WIDTH-1:0] mwr_addr;
    logic                  mwr_ready;
    logic                  mwr_error;

    logic                  mrd_addr_valid;
    logic [ADDR_WIDTH-1:0] mrd_addr;
    logic                  mrd_addr_ready;
    logic [DATA_WIDTH-1:0] mrd_data;
    logic                  mrd_data_valid;
    logic                  mrd_error;
    logic                  mrd_data_ready;

    logic                  timeout_flag;

    modport master (
        input  r0_cmd_valid, r0_cmd_we, r0_cmd_addr, r0_cmd_wdata, r0_rsp_ready,
        input  r1_cmd_valid, r1_cmd_we, r1_cmd_addr, r1_cmd_wdata, r1_rsp_ready,
        input  mwr_ready, mwr_error, mrd_addr_ready, mrd_data, mrd_data_valid, mrd_error,
        output r0_cmd_ready, r0_rsp_valid, r0_rsp_rdata, r0_rsp_err,
        output r1_cmd_ready, r1_rsp_valid, r1_rsp_rdata, r1_rsp_err,
        output mwr_valid, mwr_data, mwr_addr, mrd_addr_valid, mrd_addr, mrd_data_ready,
        output timeout_flag
    );

    modport slave (
        output r0_cmd_valid, r0_cmd_we, r0_cmd_addr, r0_cmd_wdata, r0_rsp_ready,
        output r1_cmd_valid, r1_cmd_we, r1_cmd_addr, r1_cmd_wdata, r1_rsp_ready,
        output mwr_ready, mwr_error, mrd_addr_ready, mrd_data, mrd_data_valid, mrd_error,
        input  r0_cmd_ready, r0_rsp_valid, r0_rsp_rdata, r0_rsp_err,
        input  r1_cmd_ready, r1_rsp_valid, r1_rsp_rdata, r1_rsp_err,
        input  mwr_valid, mwr_data, mwr_addr, mrd_addr_valid, mrd_addr, mrd_data_ready,
        input  timeout_flag
    );
endinterface

// File: rtl/axi_cmd_arbiter.sv
// Two-port round-robin arbiter that serialises single read/write commands onto
// the axi_lite_master command port. Only one transaction is outstanding at a time.
// A watchdog bounds every wait on the master.
module axi_cmd_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    axi_cmd_arbiter_if.master bus
);
    localparam int unsigned         CntWidth = $clog2(TIMEOUT);
    localparam logic [CntWidth-1:0] CntLast  = CntWidth'(TIMEOUT - 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StWrIssue = 3'd1;
    localparam logic [2:0] StWrBusy  = 3'd2;
    localparam logic [2:0] StWrDone  = 3'd3;
    localparam logic [2:0] StRdIssue = 3'd4;
    localparam logic [2:0] StRdWait  = 3'd5;
    localparam logic [2:0] StResp    = 3'd6;

    logic [2:0]            state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [CntWidth-1:0]   wd_cnt_q, wd_cnt_d;
    logic                  timeout_q, timeout_d;

    logic                  sel, sel_we, accept, waiting, abort, rsp_fire, in_resp;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Arbitration: on contention the requester not served last wins.
    always_comb begin
        if (bus.r0_cmd_valid && bus.r1_cmd_valid) begin
            sel = ~last_grant_q;
        end else begin
            sel = bus.r1_cmd_valid;
        end
        sel_we    = sel ? bus.r1_cmd_we    : bus.r0_cmd_we;
        sel_addr  = sel ? bus.r1_cmd_addr  : bus.r0_cmd_addr;
        sel_wdata = sel ? bus.r1_cmd_wdata : bus.r0_cmd_wdata;
        accept    = (state_q == StIdle) && (bus.r0_cmd_valid || bus.r1_cmd_valid);
        waiting   = (state_q inside {StWrIssue, StWrBusy, StWrDone, StRdIssue, StRdWait});
        abort     = waiting && (wd_cnt_q == CntLast);
        in_resp   = (state_q == StResp);
        rsp_fire  = in_resp && (grant_q ? bus.r1_rsp_ready : bus.r0_rsp_ready);
    end

    // Transaction sequencing; a watchdog abort overrides every wait state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (accept) state_d = sel_we ? StWrIssue : StRdIssue;
            StWrIssue: if (bus.mwr_ready) state_d = StWrBusy;
            StWrBusy:  if (!bus.mwr_ready) state_d = StWrDone;
            StWrDone:  if (bus.mwr_ready) state_d = StResp;
            StRdIssue: if (bus.mrd_addr_ready) state_d = StRdWait;
            StRdWait:  if (bus.mrd_data_valid) state_d = StResp;
            StResp:    if (rsp_fire) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        if (abort) state_d = StResp;
    end

    // Capture the command, accumulate errors while waiting, force the abort result.
    always_comb begin
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        timeout_d    = timeout_q | abort;
        if (accept) begin
            grant_d = sel;
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            rdata_d = '0;
            err_d   = 1'b0;
        end
        if (state_q == StWrDone) err_d = err_q | bus.mwr_error;
        if (state_q == StRdWait) begin
            err_d = err_q | bus.mrd_error;
            if (bus.mrd_data_valid) rdata_d = bus.mrd_data;
        end
        if (rsp_fire) begin
            err_d        = 1'b0;
            last_grant_d = grant_q;
        end
        if (abort) begin
            err_d   = 1'b1;
            rdata_d = '0;
        end
    end

    // Watchdog counts cycles in the current wait state and restarts on any transition.
    always_comb begin
        if (!waiting || (state_d != state_q)) begin
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + CntWidth'(1);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            wd_cnt_q     <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            wd_cnt_q     <= wd_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.r0_cmd_ready = accept && !sel;
    assign bus.r1_cmd_ready = accept && sel;

    // The response is routed only to the requester that owns the transaction.
    assign bus.r0_rsp_valid = in_resp && !grant_q;
    assign bus.r1_rsp_valid = in_resp && grant_q;
    assign bus.r0_rsp_rdata = (in_resp && !grant_q) ? rdata_q : '0;
    assign bus.r1_rsp_rdata = (in_resp && grant_q) ? rdata_q : '0;
    assign bus.r0_rsp_err   = in_resp && !grant_q && err_q;
    assign bus.r1_rsp_err   = in_resp && grant_q && err_q;

    // Master strobes drop in the abort cycle, so no handshake completes as the wait ends.
    assign bus.mwr_valid      = (state_q == StWrIssue) && bus.mwr_ready && !abort;
    assign bus.mwr_addr       = addr_q;
    assign bus.mwr_data       = wdata_q;
    assign bus.mrd_addr_valid = (state_q == StRdIssue) && !abort;
    assign bus.mrd_addr       = addr_q;
    assign bus.mrd_data_ready = (state_q == StRdWait) && !abort;
    assign bus.timeout_flag   = timeout_q;
endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Randomised bench for axi_cmd_arbiter. Two requester drivers and a behavioural
// axi_lite_master stand-in are checked against a transaction-level model.
module tb_axi_cmd_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_cmd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_cmd_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Requester drivers
    logic          req_v     [2];
    logic          req_we    [2];
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_wdata [2];
    bit            gen_en, gen_full, rsp_hold, hang;
    int            force_wlat;

    // Master stand-in: write busy countdown, read phase 0 idle / 1 delay / 2 data
    int            wr_cnt, rd_state, rd_cnt;
    bit            wr_err_pend, rd_err;
    logic [DW-1:0] rd_data;

    // Transaction-level model
    bit            busy, issued, expect_abort, last_grant, exp_tflag, seen_rsp;
    int            cur_id, grant_cyc, busy_cyc;
    bit            cur_we;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata, exp_rdata;
    bit            exp_err;
    int            done_cnt [2];
    int            grant_log[$];
    logic          pv [2], pr [2], pe [2];
    logic [DW-1:0] pd [2];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        busy = 0; issued = 0; expect_abort = 0; last_grant = 1; exp_tflag = 0; seen_rsp = 0;
        wr_cnt = 0; wr_err_pend = 0; rd_state = 0; rd_cnt = 0; force_wlat = 0;
        for (int n = 0; n < 2; n++) begin
            pv[n] = 0; pr[n] = 0; pe[n] = 0; pd[n] = '0;
        end
    endtask

    // One clock: drive inputs after the falling edge, then sample what the rising edge will see.
    task automatic step();
        logic [1:0]    exp_rdy, got_rdy;
        logic          rv [2], re [2], rr [2];
        logic [DW-1:0] rdat [2];
        logic          slave_done;
        int            sel;
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            if (gen_en && !req_v[n] && (gen_full || $urandom_range(0, 2) == 0)) begin
                req_v[n]     = 1'b1;
                req_we[n]    = 1'($urandom_range(0, 1));
                req_addr[n]  = AW'($urandom_range(0, 1023) * 4);
                req_wdata[n] = DW'($urandom);
            end
        end
        bus.r0_cmd_valid = req_v[0];  bus.r0_cmd_we = req_we[0];
        bus.r0_cmd_addr  = req_addr[0]; bus.r0_cmd_wdata = req_wdata[0];
        bus.r1_cmd_valid = req_v[1];  bus.r1_cmd_we = req_we[1];
        bus.r1_cmd_addr  = req_addr[1]; bus.r1_cmd_wdata = req_wdata[1];
        bus.r0_rsp_ready = !rsp_hold && ($urandom_range(0, 1) == 1);
        bus.r1_rsp_ready = !rsp_hold && ($urandom_range(0, 1) == 1);
        bus.mwr_ready      = (wr_cnt == 0);
        bus.mwr_error      = (wr_cnt == 0) && wr_err_pend;
        if (wr_cnt == 0) wr_err_pend = 0;
        bus.mrd_addr_ready = (rd_state == 0) && !hang && ($urandom_range(0, 3) != 0);
        bus.mrd_data_valid = (rd_state == 2);
        bus.mrd_data       = (rd_state == 2) ? rd_data : DW'($urandom);
        bus.mrd_error      = (rd_state == 2) && rd_err;
        #1;
        cyc++;
        rv[0] = bus.r0_rsp_valid; rdat[0] = bus.r0_rsp_rdata; re[0] = bus.r0_rsp_err;
        rv[1] = bus.r1_rsp_valid; rdat[1] = bus.r1_rsp_rdata; re[1] = bus.r1_rsp_err;
        rr[0] = bus.r0_rsp_ready; rr[1] = bus.r1_rsp_ready;

        // Arbitration: free arbiter grants the sole requester, or alternates on contention.
        sel = (req_v[0] && req_v[1]) ? (last_grant ? 0 : 1) : (req_v[1] ? 1 : 0);
        exp_rdy = '0;
        if (!rst && !busy && (req_v[0] || req_v[1])) exp_rdy[sel] = 1'b1;
        got_rdy = {bus.r1_cmd_ready, bus.r0_cmd_ready};
        check_val("cmd_ready", 64'(got_rdy), 64'(exp_rdy));
        if (exp_rdy != 2'b00) begin
            busy = 1; issued = 0; seen_rsp = 0; busy_cyc = 0; grant_cyc = cyc;
            cur_id = sel; cur_we = req_we[sel]; cur_addr = req_addr[sel];
            cur_wdata = req_wdata[sel]; req_v[sel] = 1'b0;
            grant_log.push_back(sel);
        end

        // Master stand-in bookkeeping
        if (wr_cnt > 0) wr_cnt--;
        if (rd_state == 2) begin
            check_val("mrd_data_ready", 64'(bus.mrd_data_ready), 64'(1));
            rd_state = 0;
        end else if (rd_state == 1) begin
            rd_cnt--;
            if (rd_cnt == 0) rd_state = 2;
        end
        if (bus.mwr_valid) begin
            check_val("wr_issue_legal", 64'({busy, cur_we, issued, bus.mwr_ready}), 64'(4'b1101));
            check_val("mwr_addr", 64'(bus.mwr_addr), 64'(cur_addr));
            check_val("mwr_data", 64'(bus.mwr_data), 64'(cur_wdata));
            issued      = 1;
            wr_cnt      = (force_wlat != 0) ? force_wlat : $urandom_range(1, 5);
            wr_err_pend = ($urandom_range(0, 3) == 0);
            exp_err     = wr_err_pend;
            exp_rdata   = '0;
        end
        if (bus.mrd_addr_valid) begin
            check_val("rd_issue_legal", 64'({busy, cur_we, issued}), 64'(3'b100));
        end
        if (bus.mrd_addr_valid && bus.mrd_addr_ready) begin
            check_val("mrd_addr", 64'(bus.mrd_addr), 64'(cur_addr));
            issued    = 1;
            rd_state  = 1;
            rd_cnt    = $urandom_range(1, 5);
            rd_data   = DW'($urandom);
            rd_err    = ($urandom_range(0, 3) == 0);
            exp_rdata = rd_data;
            exp_err   = rd_err;
        end

        // Responses
        slave_done = issued && (cur_we ? (wr_cnt == 0) : (rd_state == 0));
        for (int n = 0; n < 2; n++) begin
            if (pv[n] && !pr[n] && !rst) begin
                check_val("rsp_hold", 64'({rv[n], re[n], rdat[n]}), 64'({1'b1, pe[n], pd[n]}));
            end
            if (rv[n]) begin
                check_val("rsp_legal", 64'({busy, cur_id == n, expect_abort || slave_done}),
                          64'(3'b111));
                if (expect_abort && !seen_rsp) begin
                    check_val("abort_latency", 64'(cyc - grant_cyc), 64'(TO + 1));
                    exp_tflag = 1;
                end
                seen_rsp = 1;
                if (rr[n]) begin
                    check_val("rsp_rdata", 64'(rdat[n]), 64'(exp_rdata));
                    check_val("rsp_err", 64'(re[n]), 64'(exp_err));
                    busy = 0; last_grant = 1'(n); expect_abort = 0;
                    done_cnt[n]++;
                end
            end
            pv[n] = rv[n]; pr[n] = rr[n]; pd[n] = rdat[n]; pe[n] = re[n];
        end
        check_val("timeout_flag", 64'(bus.timeout_flag), 64'(exp_tflag));
        if (busy) begin
            busy_cyc++;
            if (busy_cyc == 200) check_val("txn_stuck", 64'(busy_cyc), 64'(0));
        end
    endtask

    task automatic issue(input int n, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
        req_v[n] = 1'b1; req_we[n] = we; req_addr[n] = addr; req_wdata[n] = wdata;
    endtask

    task automatic run_until_done(input int n, input int bound);
        int start;
        int i;
        start = done_cnt[n];
        i = 0;
        while (done_cnt[n] == start && i < bound) begin
            step();
            i++;
        end
        check_val("txn_done", 64'(done_cnt[n] - start), 64'(1));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_ctrl"}, 64'({bus.r0_cmd_ready, bus.r1_cmd_ready, bus.r0_rsp_valid,
                  bus.r1_rsp_valid, bus.r0_rsp_err, bus.r1_rsp_err, bus.mwr_valid,
                  bus.mrd_addr_valid, bus.mrd_data_ready, bus.timeout_flag}), 64'(0));
        check_val({tag, "_data"}, 64'(bus.r0_rsp_rdata | bus.r1_rsp_rdata | bus.mwr_data |
                  bus.mwr_addr | bus.mrd_addr), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b1;
        gen_en = 0; gen_full = 0; rsp_hold = 0; hang = 0;
        done_cnt[0] = 0; done_cnt[1] = 0;
        for (int n = 0; n < 2; n++) begin
            req_v[n] = 0; req_we[n] = 0; req_addr[n] = '0; req_wdata[n] = '0;
        end
        model_reset();
        rd_data = '0; rd_err = 0; cur_id = 0; cur_we = 0; cur_addr = '0; cur_wdata = '0;
        exp_rdata = '0; exp_err = 0; grant_cyc = 0; busy_cyc = 0;
        repeat (3) step();
        check_idle_outputs("reset");
        rst = 1'b0;

        // Directed: r0 write, then r1 read
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF);
        run_until_done(0, 60);
        issue(1, 1'b0, 32'h20, '0);
        run_until_done(1, 60);

        // Random traffic from both requesters
        gen_en = 1;
        repeat (3000) step();
        gen_en = 0;
        for (int i = 0; i < 300 && (busy || req_v[0] || req_v[1]); i++) step();
        check_val("drain", 64'({busy, req_v[0], req_v[1]}), 64'(0));
        check_val("r0_served", 64'(done_cnt[0] > 100), 64'(1));
        check_val("r1_served", 64'(done_cnt[1] > 100), 64'(1));

        // Both requesters continuously valid: grants must alternate
        grant_log.delete();
        begin
            int first;
            first = last_grant ? 0 : 1;
            gen_en = 1; gen_full = 1;
            for (int i = 0; i < 200 && grant_log.size() < 4; i++) step();
            gen_en = 0; gen_full = 0;
            check_val("alt_grant_count", 64'(grant_log.size() >= 4), 64'(1));
            for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
                check_val("alt_grant", 64'(grant_log[i]), 64'((first + i) % 2));
            end
        end
        for (int i = 0; i < 300 && (busy || req_v[0] || req_v[1]); i++) step();
        check_val("drain2", 64'({busy, req_v[0], req_v[1]}), 64'(0));

        // Hung read: watchdog abort, sticky timeout_flag
        hang = 1; expect_abort = 1; exp_err = 1; exp_rdata = '0;
        issue(0, 1'b0, 32'h40, '0);
        run_until_done(0, 100);
        hang = 0;
        check_val("tflag_after_abort", 64'(bus.timeout_flag), 64'(1));
        issue(1, 1'b0, 32'h20, '0);
        run_until_done(1, 60);

        // Reset while a write sits in its completion wait with the response unconsumed
        rsp_hold = 1; force_wlat = 8;
        issue(0, 1'b1, 32'h80, 32'hA5A5_5A5A);
        for (int i = 0; i < 40 && !issued; i++) step();
        check_val("wr_issued", 64'(issued), 64'(1));
        repeat (4) step();
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        model_reset();
        rsp_hold = 0;
        repeat (2) step();
        rst = 1'b0;
        issue(1, 1'b0, 32'h24, '0);
        run_until_done(1, 60);
        check_val("post_reset_tflag", 64'(bus.timeout_flag), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/axi_cmd_arbiter.md
# axi_cmd_arbiter

Two-port round-robin arbiter and transaction sequencer placed in front of the `axi_lite_master` custom command interface (`mwr_*` / `mrd_*`). Two requesters, e.g. the UART command decoder and an on-chip register poller, each issue single read or write commands. The block serialises them onto the master, one transaction outstanding at a time. It tracks completion, latches the error flag and returns a response to the originating requester. A watchdog counter bounds every wait so a requester is never starved by a hung slave.

## Interface
- `ADDR_WIDTH`, 32, address width (matches master).
- `DATA_WIDTH`, 32, data width (matches master).
- `TIMEOUT`, 1024, max cycles spent in any wait state before abort; must be ≥ 4.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rN_cmd_valid`  in  1  requester N (N=0,1) command valid.
- `rN_cmd_we`  in  1  1 = write, 0 = read.
- `rN_cmd_addr`  in  ADDR_WIDTH  byte address.
- `rN_cmd_wdata`  in  DATA_WIDTH  write data.
- `rN_cmd_ready`  out  1  command accepted this cycle.
- `rN_rsp_valid`  out  1  response valid.
- `rN_rsp_rdata`  out  DATA_WIDTH  read data (0 for writes and aborts).
- `rN_rsp_err`  out  1  slave error (RESP[1]) or timeout.
- `rN_rsp_ready`  in  1  requester consumes response.
- `mwr_valid`, `mwr_data`, `mwr_addr`  out  1/DATA/ADDR  write command to master.
- `mwr_ready`, `mwr_error`  in  1/1  master write idle, write error pulse.
- `mrd_addr_valid`, `mrd_addr`  out  1/ADDR  read command to master.
- `mrd_addr_ready`  in  1  master read idle.
- `mrd_data`, `mrd_data_valid`, `mrd_error`  in  DATA/1/1  read return.
- `mrd_data_ready`  out  1  read data accept.
- `timeout_flag`  out  1  sticky; set on any abort, cleared only by `rst`.

## Operation
- States: IDLE, WR_ISSUE, WR_BUSY, WR_DONE, RD_ISSUE, RD_WAIT, RESP.
- IDLE: if exactly one `rN_cmd_valid`, grant N. If both are valid, grant the requester not granted last (`last_grant`, reset = 1, so r0 wins first). `rN_cmd_ready` = 1 combinationally for the granted N in IDLE only. We/addr/wdata are captured on that edge. Go to WR_ISSUE or RD_ISSUE.
- WR_ISSUE: wait for `mwr_ready`=1, then drive `mwr_valid`=1 for exactly one cycle with captured addr/data. Go to WR_BUSY.
- WR_BUSY: wait for `mwr_ready`=0 (master has taken the command). Go to WR_DONE.
- WR_DONE: OR `mwr_error` into `err_q` every cycle. On `mwr_ready`=1, go to RESP.
- RD_ISSUE: hold `mrd_addr_valid`=1 until `mrd_addr_valid & mrd_addr_ready`. Go to RD_WAIT.
- RD_WAIT: `mrd_data_ready`=1. OR `mrd_error` into `err_q`. On `mrd_data_valid`, capture `mrd_data` and go to RESP.
- RESP: `rN_rsp_valid`=1 for the granted N only, with data = captured value and err = `err_q`. On `rN_rsp_ready`, clear `err_q`, update `last_grant`=N and go to IDLE.
- Watchdog: counter cleared on every state change, incremented in WR_ISSUE/WR_BUSY/WR_DONE/RD_ISSUE/RD_WAIT. On reaching TIMEOUT-1, force err=1 and rdata=0, set `timeout_flag`, drop any master valid and go to RESP. Master recovery after an abort is out of scope.
- The non-granted requester's command is held pending; it wins the next arbitration if still valid.

## Timing
- Reset values: all `*_cmd_ready`, `*_rsp_valid`, `*_rsp_err`, `mwr_valid`, `mrd_addr_valid`, `mrd_data_ready`, and `timeout_flag` are 0. Data/address outputs are 0. State = IDLE.
- Reset asserted mid-transaction: immediate return to IDLE and all outputs to reset values. No response is issued.
- Accept to master command: ≥1 cycle (WR_ISSUE/RD_ISSUE entered the cycle after `cmd_ready`).
- Response to next accept: RESP→IDLE takes 1 cycle. Minimum turnaround is 1 idle cycle between commands.
- `rN_rsp_valid` stays high and stable until `rN_rsp_ready`. `rN_rsp_ready` outside RESP is ignored.
- An error pulse arriving in the same cycle as the completion condition is still captured in that response.

## Test plan
- r0 write addr 0x10 data 0xDEADBEEF, slave OKAY → one `mwr_valid` pulse with matching addr/data; `r0_rsp_valid` after `mwr_ready` rises; err=0, rdata=0.
- r1 read addr 0x20, slave returns 0x12345678 OKAY → `r1_rsp_rdata`=0x12345678, err=0; r0 outputs stay idle.
- r0 and r1 both valid continuously for 4 commands → grants r0,r1,r0,r1; never two master commands outstanding.
- Read with RRESP=2'b10 → `mrd_error` pulse latched, `rsp_err`=1; following OKAY read returns err=0.
- TIMEOUT=16, slave never answers read → RESP after 16 cycles in RD_ISSUE, err=1, rdata=0, `timeout_flag`=1 until `rst`.
- `rst` pulsed during WR_DONE with `rN_rsp_ready` held 0 → all outputs 0 immediately; fresh r1 read after reset completes normally.
